ser_frame_gen: RTL and testbench
================================

// Module: ser_frame_gen
// PURPOSE
//   Serial frame generator: the sending end of the single-wire serial protocol consumed by the lab's
//   serial transmitter. Latches a port/length/payload request, then shifts one frame bit per clkEn
//   (single-step pulse from the one-pulser) onto serOut, which feeds the receiver's serIn.
//   Frame = start bit '0', 2-bit port (MSB first), 4-bit length (MSB first), length payload bits (data[0] first).
//   Line idles at '1'. Exposes remaining payload bits for the 7-segment display.
// PARAMETERS
//   DATA_W   16   payload register width; max frame payload = min(len, DATA_W) bits
//   LEN_W    4    width of length field and of bits_left
// PORTS
//   clk        in   1       system clock, all state on rising edge
//   rst        in   1       synchronous reset, active-low
//   clkEn      in   1       one-cycle bit-advance strobe
//   start      in   1       frame request, sampled each clk while IDLE
//   port       in   2       destination port, latched on accepted start
//   len        in   LEN_W   payload bit count 0..15, latched on accepted start
//   data       in   DATA_W  payload, latched on accepted start, sent LSB first
//   serOut     out  1       serial line to receiver serIn
//   busy       out  1       1 from accepted start until return to IDLE
//   done       out  1       one-clk pulse when frame completes
//   bits_left  out  LEN_W   payload bits not yet driven (for SSD)
// BEHAVIOUR
//   Reset (rst==0 at clk edge): state IDLE, serOut=1, busy=0, done=0, bits_left=0, shift regs cleared.
//   Reset has priority over every other input, including mid-frame: frame discarded, line returns to 1.
//   States: IDLE, ARMED, START, PORT, LEN, DATA, STOP.
//   IDLE:  serOut=1. start==1 -> latch port/len/data, bits_left<=len, busy<=1, ARMED (same cycle's
//          clkEn ignored). start while not IDLE ignored.
//   ARMED: serOut=1. clkEn -> serOut<=0, START.
//   START: clkEn -> serOut<=port[1], PORT; port bit index 1 then 0 on successive clkEn.
//   PORT:  after port[0] presented, clkEn -> serOut<=len[3], LEN; len[3..0] on successive clkEn.
//   LEN:   after len[0] presented, clkEn -> if len!=0: serOut<=data[0], bits_left<=len-1, DATA;
//          if len==0: serOut<=1, STOP.
//   DATA:  each clkEn shifts payload right; serOut<=next bit, bits_left decrements; when bits_left==0
//          at clkEn -> serOut<=1, STOP. No underflow of bits_left.
//   STOP:  next clk (clkEn not required): done<=1 for exactly one clk, busy<=0, IDLE.
//   Each bit is held on serOut from one clkEn edge to the next; receiver samples at clkEn.
//   Bit count per frame = 1 + 2 + 4 + len clkEn strobes, then line high.
//   len > DATA_W: payload bits beyond DATA_W are sent as 0.
//   clkEn while IDLE or STOP: no effect. clkEn held high: advances one bit per clk (legal).
//   serOut, busy, done, bits_left are registered; no combinational path from inputs to outputs.
// TESTING
//   Reset: rst=0 for 2 clk mid-frame -> serOut=1, busy=0, done=0, bits_left=0 next cycle.
//   port=2'b10, len=4'd3, data=16'h0005, start, 10 clkEn -> serOut seq 0,1,0,0,0,1,1,1,0,1 then 1;
//     bits_left 3,3..,2,1,0; done pulses once one clk after 10th strobe + 1.
//   len=0, port=2'b01 -> 7 clkEn give 0,0,1,0,0,0,0 then line 1, done pulse; bits_left stays 0.
//   start asserted again while busy (mid-DATA) -> ignored, latched fields unchanged, frame intact.
//   len=4'd15, data=16'hFFFF, clkEn tied high -> 22 consecutive bit clks, then done, busy falls.
//   Loopback: serOut into serial transmitter serIn with shared clkEn -> receiver routes payload
//     to port 2 with serOutValid for exactly len strobes.

Source files
------------

// File: rtl/ser_frame_gen.sv
// Serial frame generator: sending end of the single-wire serial protocol.
// Latches a port/length/payload request and shifts one frame bit per clkEn
// strobe onto serOut. Frame: start '0', port[1:0] MSB first, len MSB first,
// then len payload bits starting at data[0]. Line idles high.
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst        synchronous reset, active-low
//   clkEn      one-cycle bit-advance strobe
//   start      frame request, sampled while idle
//   port       destination port, latched on accepted start
//   len        payload bit count, latched on accepted start
//   data       payload, latched on accepted start, sent LSB first
//   serOut     serial line (registered)
//   busy       high from accepted start until return to idle
//   done       one-clk pulse when a frame completes
//   bits_left  payload bits not yet driven
module ser_frame_gen #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clkEn,
  input  logic              start,
  input  logic [1:0]        port,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] data,
  output logic              serOut,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  bits_left
);

  // Field bit index; must hold at least the port index (1) and LEN_W-1.
  localparam int unsigned IdxW = (LEN_W <= 2) ? 1 : $clog2(LEN_W);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StArmed = 3'd1;
  localparam logic [2:0] StStart = 3'd2;
  localparam logic [2:0] StPort  = 3'd3;
  localparam logic [2:0] StLen   = 3'd4;
  localparam logic [2:0] StData  = 3'd5;
  localparam logic [2:0] StStop  = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [1:0]        port_q, port_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [LEN_W-1:0]  bits_left_q, bits_left_d;
  logic              ser_q, ser_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    port_d      = port_q;
    len_d       = len_q;
    shift_d     = shift_q;
    bits_left_d = bits_left_q;
    ser_d       = ser_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      StIdle: begin
        ser_d = 1'b1;
        // The clkEn of the accepting cycle is deliberately ignored.
        if (start) begin
          port_d      = port;
          len_d       = len;
          shift_d     = data;
          bits_left_d = len;
          busy_d      = 1'b1;
          state_d     = StArmed;
        end
      end
      StArmed: begin
        if (clkEn) begin
          ser_d   = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (clkEn) begin
          ser_d   = port_q[1];
          idx_d   = IdxW'(1);
          state_d = StPort;
        end
      end
      StPort: begin
        if (clkEn) begin
          if (idx_q != '0) begin
            ser_d = port_q[0];
            idx_d = '0;
          end else begin
            ser_d   = len_q[LEN_W-1];
            idx_d   = IdxW'(LEN_W - 1);
            state_d = StLen;
          end
        end
      end
      StLen: begin
        if (clkEn) begin
          if (idx_q != '0) begin
            ser_d = len_q[idx_q - IdxW'(1)];
            idx_d = idx_q - IdxW'(1);
          end else if (len_q != '0) begin
            // Zeros shift in from the top, so bits beyond DATA_W go out as 0.
            ser_d       = shift_q[0];
            shift_d     = shift_q >> 1;
            bits_left_d = len_q - LEN_W'(1);
            state_d     = StData;
          end else begin
            ser_d   = 1'b1;
            state_d = StStop;
          end
        end
      end
      StData: begin
        if (clkEn) begin
          if (bits_left_q == '0) begin
            ser_d   = 1'b1;
            state_d = StStop;
          end else begin
            ser_d       = shift_q[0];
            shift_d     = shift_q >> 1;
            bits_left_d = bits_left_q - LEN_W'(1);
          end
        end
      end
      StStop: begin
        ser_d   = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        ser_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      port_q      <= '0;
      len_q       <= '0;
      shift_q     <= '0;
      bits_left_q <= '0;
      ser_q       <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      port_q      <= port_d;
      len_q       <= len_d;
      shift_q     <= shift_d;
      bits_left_q <= bits_left_d;
      ser_q       <= ser_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign serOut    = ser_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign bits_left = bits_left_q;

endmodule

// File: tb/tb_ser_frame_gen.sv
// Bench for ser_frame_gen: a frame-level reference model (bit list plus a
// count of strobes consumed) checked against the DUT on every falling edge,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ser_frame_gen;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned LEN_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              clkEn = 1'b0;
  logic              start = 1'b0;
  logic [1:0]        port = '0;
  logic [LEN_W-1:0]  len = '0;
  logic [DATA_W-1:0] data = '0;
  logic              serOut;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  bits_left;

  ser_frame_gen #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clkEn     (clkEn),
    .start     (start),
    .port      (port),
    .len       (len),
    .data      (data),
    .serOut    (serOut),
    .busy      (busy),
    .done      (done),
    .bits_left (bits_left)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference model: the whole frame as a bit list; m_pos = strobes consumed.
  bit m_frame [0:31];
  int m_nbits = 0;
  int m_pos   = 0;
  int m_len   = 0;
  bit m_busy  = 1'b0;
  bit m_stop  = 1'b0;
  bit m_done  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (!rst) begin
      m_busy = 1'b0; m_stop = 1'b0; m_done = 1'b0; m_pos = 0; m_len = 0;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_len      = int'(len);
          m_nbits    = 7 + m_len;
          m_frame[0] = 1'b0;
          m_frame[1] = port[1];
          m_frame[2] = port[0];
          for (int i = 0; i < 4; i++) m_frame[3 + i] = len[3 - i];
          for (int j = 0; j < m_len; j++) m_frame[7 + j] = (j < DATA_W) ? data[j] : 1'b0;
          m_pos  = 0;
          m_busy = 1'b1;
        end
      end else if (m_stop) begin
        m_busy = 1'b0;
        m_stop = 1'b0;
        m_done = 1'b1;
      end else if (clkEn) begin
        if (m_pos < m_nbits) m_pos++;
        else m_stop = 1'b1;
      end
    end
  endtask

  // Advance one clock: model sees the same inputs the DUT samples.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic strobe();
    clkEn = 1'b1;
    step();
    clkEn = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic exp_ser;
      int   exp_bl;
      exp_ser = (m_busy && !m_stop && m_pos > 0) ? m_frame[m_pos - 1] : 1'b1;
      exp_bl  = !m_busy ? 0 : (m_pos > 7 ? m_len - (m_pos - 7) : m_len);
      check("model_serOut", 32'(serOut), 32'(exp_ser));
      check("model_busy", 32'(busy), 32'(m_busy));
      check("model_done", 32'(done), 32'(m_done));
      check("model_bits_left", 32'(bits_left), 32'(exp_bl));
    end
  end

  initial begin
    logic [9:0]  e1;
    logic [6:0]  e2;
    logic [11:0] e3;
    logic [3:0]  bl_exp [0:9];
    int n;

    // Power-on reset.
    rst = 1'b0;
    step();
    step();
    chk_en = 1'b1;
    check("reset_serOut", 32'(serOut), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_bits_left", 32'(bits_left), 32'd0);
    rst = 1'b1;

    // Mid-frame reset discards the frame.
    port = 2'b11; len = 4'd9; data = 16'hA5A5; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 9; i++) strobe();
    rst = 1'b0;
    step();
    step();
    check("midrst_serOut", 32'(serOut), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_bits_left", 32'(bits_left), 32'd0);
    rst = 1'b1;
    step();

    // port=10 len=3 data=5, strobes separated by idle cycles.
    e1 = 10'b0100011101;
    bl_exp = '{4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd2, 4'd1, 4'd0};
    port = 2'b10; len = 4'd3; data = 16'h0005; start = 1'b1;
    step();
    start = 1'b0;
    check("f1_busy_after_start", 32'(busy), 32'd1);
    check("f1_armed_line", 32'(serOut), 32'd1);
    for (int i = 0; i < 10; i++) begin
      strobe();
      check($sformatf("f1_bit%0d", i), 32'(serOut), 32'(e1[9 - i]));
      check($sformatf("f1_bl%0d", i), 32'(bits_left), 32'(bl_exp[i]));
      step();
    end
    strobe();
    check("f1_stop_line", 32'(serOut), 32'd1);
    check("f1_stop_busy", 32'(busy), 32'd1);
    check("f1_stop_done", 32'(done), 32'd0);
    step();
    check("f1_done_pulse", 32'(done), 32'd1);
    check("f1_busy_fall", 32'(busy), 32'd0);
    step();
    check("f1_done_once", 32'(done), 32'd0);

    // len=0, port=01.
    e2 = 7'b0010000;
    port = 2'b01; len = 4'd0; data = 16'hFFFF; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      strobe();
      check($sformatf("f2_bit%0d", i), 32'(serOut), 32'(e2[6 - i]));
      check($sformatf("f2_bl%0d", i), 32'(bits_left), 32'd0);
    end
    strobe();
    check("f2_stop_line", 32'(serOut), 32'd1);
    step();
    check("f2_done_pulse", 32'(done), 32'd1);
    step();

    // start while busy (mid-DATA) must not disturb the frame.
    e3 = 12'b011010101101;
    port = 2'b11; len = 4'd5; data = 16'h0016; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      strobe();
      check($sformatf("f3_bit%0d", i), 32'(serOut), 32'(e3[11 - i]));
      if (i == 8) begin
        port = 2'b00; len = 4'd9; data = 16'hFFFF; start = 1'b1;
        step();
        start = 1'b0;
      end
    end
    check("f3_bl_end", 32'(bits_left), 32'd0);
    strobe();
    step();
    check("f3_done_pulse", 32'(done), 32'd1);
    step();

    // clkEn held high: 22 bits, stop, then done 25 edges after the start edge.
    port = 2'b10; len = 4'd15; data = 16'hFFFF; start = 1'b1; clkEn = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    while (!done && n < 100) begin
      step();
      n++;
    end
    check("f4_edges_to_done", 32'(n), 32'd25);
    check("f4_busy_fall", 32'(busy), 32'd0);
    clkEn = 1'b0;
    step();

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      rst   = ($urandom_range(0, 299) != 0);
      start = ($urandom_range(0, 3) == 0);
      port  = 2'($urandom);
      len   = LEN_W'($urandom);
      data  = DATA_W'($urandom);
      clkEn = (c % 500 < 100) ? 1'b1 : ($urandom_range(0, 2) == 0);
      step();
    end
    rst = 1'b1; start = 1'b0; clkEn = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
